// File: rtl/perf_pkg.sv
// Shared constants for the performance counter unit: counter map, widths and FSM encoding.
package perf_pkg;

  localparam int NUM_CTR = 8;
  localparam int CTR_W   = 32;
  localparam int HALF_W  = 16;

  localparam int CTR_CYCLES  = 0;
  localparam int CTR_RETIRED = 1;
  localparam int CTR_IC_REQ  = 2;
  localparam int CTR_IC_HIT  = 3;
  localparam int CTR_DC_REQ  = 4;
  localparam int CTR_DC_HIT  = 5;
  localparam int CTR_STALL   = 6;
  localparam int CTR_MEM_OPS = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/perf_sat_ctr.sv
// Single saturating event counter with a sticky flag raised when an increment is lost at full scale.
module perf_sat_ctr
  import perf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             freeze,
  output logic [CTR_W-1:0] value,
  output logic             ovf
);

  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc && !freeze) begin
      // At full scale the increment is dropped and the loss is recorded instead.
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + {{(CTR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign value = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Eight commit/cache/stall performance counters gated by a run/halt FSM, read out 16 bits at a time.
module perf_counter_unit
  import perf_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         reg_write,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         halt,
  input  logic         err,
  input  logic         icache_req,
  input  logic         icache_hit,
  input  logic         dcache_req,
  input  logic         dcache_hit,
  input  logic         mem_stall,
  input  logic         rd_en,
  input  logic [3:0]   rd_sel,
  output logic [15:0]  rd_data,
  output logic         rd_valid,
  output logic [7:0]   ovf,
  output logic         halted,
  output logic         err_seen,
  output logic [1:0]   state
);

  state_e              state_q;
  logic                halted_q, err_seen_q;
  logic                count_en;
  logic [NUM_CTR-1:0]  ev;
  logic [CTR_W-1:0]    ctr_val [NUM_CTR];
  logic [HALF_W-1:0]   hold_q, rd_data_q;
  logic                rd_valid_q;
  logic [2:0]          rd_idx;

  assign count_en = (state_q == ST_RUN) && en;

  always_comb begin
    ev              = '0;
    ev[CTR_CYCLES]  = 1'b1;
    ev[CTR_RETIRED] = halt | reg_write | mem_write;
    ev[CTR_IC_REQ]  = icache_req;
    ev[CTR_IC_HIT]  = icache_hit;
    ev[CTR_DC_REQ]  = dcache_req;
    ev[CTR_DC_HIT]  = dcache_hit;
    ev[CTR_STALL]   = mem_stall;
    ev[CTR_MEM_OPS] = mem_read | mem_write;
  end

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    perf_sat_ctr u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (ev[i]),
      .clr    (clr),
      .freeze (!count_en),
      .value  (ctr_val[i]),
      .ovf    (ovf[i])
    );
  end

  // The halt/err cycle itself still counts; the HALTED state freezes counters from the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      halted_q   <= 1'b0;
      err_seen_q <= 1'b0;
    end else if (clr) begin
      state_q    <= ST_IDLE;
      halted_q   <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_q <= ST_RUN;
        ST_RUN: begin
          if (en && (halt || err)) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (count_en && err) err_seen_q <= 1'b1;
    end
  end

  assign rd_idx = rd_sel[3:1];

  // A low-half read snapshots the upper half so the following high-half read is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_sel[0] ? hold_q : ctr_val[rd_idx][HALF_W-1:0];
      if (clr)                       hold_q <= '0;
      else if (rd_en && !rd_sel[0])  hold_q <= ctr_val[rd_idx][CTR_W-1:HALF_W];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign halted   = halted_q;
  assign err_seen = err_seen_q;
  assign state    = state_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit.
module tb_perf_counter_unit;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic        reg_write, mem_read, mem_write, halt, err;
  logic        icache_req, icache_hit, dcache_req, dcache_hit, mem_stall;
  logic        rd_en;
  logic [3:0]  rd_sel;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [7:0]  ovf;
  logic        halted, err_seen;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_mis = 0;

  perf_counter_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .halt       (halt),
    .err        (err),
    .icache_req (icache_req),
    .icache_hit (icache_hit),
    .dcache_req (dcache_req),
    .dcache_hit (dcache_hit),
    .mem_stall  (mem_stall),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .ovf        (ovf),
    .halted     (halted),
    .err_seen   (err_seen),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One-cycle read; response sampled on the following falling edge.
  task automatic rd(input logic [3:0] sel, input string tag, input logic [15:0] expv);
    rd_en  = 1'b1;
    rd_sel = sel;
    tick(1);
    rd_en  = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(tag, {16'd0, rd_data}, {16'd0, expv});
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0; err = 1'b0;
    icache_req = 1'b0; icache_hit = 1'b0; dcache_req = 1'b0; dcache_hit = 1'b0; mem_stall = 1'b0;
    rd_en = 1'b0; rd_sel = 4'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_state",    {30'd0, state},    32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data",  {16'd0, rd_data},  32'd0);
    chk("rst_ovf",      {24'd0, ovf},      32'd0);
    chk("rst_halted",   {31'd0, halted},   32'd0);
    chk("rst_err_seen", {31'd0, err_seen}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic counting: 10 RUN cycles with reg_write on 4 of them.
    en = 1'b1;
    tick(1);
    chk("t1_state_run", {30'd0, state}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      reg_write = (i == 1 || i == 3 || i == 4 || i == 8);
      tick(1);
    end
    reg_write = 1'b0;
    en = 1'b0;
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t1_en0_ignores_halt", {30'd0, state}, 32'd1);
    chk("t1_halted_low", {31'd0, halted}, 32'd0);
    rd(4'd2, "t1_retired_lo", 16'h0004);
    rd(4'd3, "t1_retired_hi", 16'h0000);
    rd(4'd0, "t1_cycles_lo",  16'h000A);
    chk("t1_rd_valid_drop", {31'd0, rd_valid}, 32'd1);
    tick(1);
    chk("t1_rd_valid_idle", {31'd0, rd_valid}, 32'd0);

    // Halt on RUN cycle 5, then counters frozen for 20 cycles.
    do_clr();
    chk("t2_clr_state", {30'd0, state}, 32'd0);
    en = 1'b1;
    tick(1);
    for (int i = 1; i <= 5; i++) begin
      halt = (i == 5);
      tick(1);
    end
    halt = 1'b0;
    chk("t2_halted", {31'd0, halted}, 32'd1);
    chk("t2_state",  {30'd0, state},  32'd2);
    reg_write = 1'b1; dcache_req = 1'b1; mem_read = 1'b1;
    tick(20);
    reg_write = 1'b0; dcache_req = 1'b0; mem_read = 1'b0;
    rd(4'd0, "t2_cycles",  16'h0005);
    rd(4'd2, "t2_retired", 16'h0001);
    rd(4'd8, "t2_dcache",  16'h0000);
    rd(4'd14, "t2_memops", 16'h0000);

    // Clear and halt together from RUN.
    do_clr();
    tick(1);
    chk("t3_clr_state", {30'd0, state}, 32'd1);
    reg_write = 1'b1;
    tick(3);
    clr = 1'b1; halt = 1'b1; err = 1'b1;
    tick(1);
    clr = 1'b0; halt = 1'b0; err = 1'b0; reg_write = 1'b0; en = 1'b0;
    chk("t3_state_idle", {30'd0, state},    32'd0);
    chk("t3_halted",     {31'd0, halted},   32'd0);
    chk("t3_err_seen",   {31'd0, err_seen}, 32'd0);
    rd(4'd0, "t3_cycles",  16'h0000);
    rd(4'd2, "t3_retired", 16'h0000);

    // Error in RUN: sticky err_seen, halts.
    en = 1'b1;
    tick(1);
    err = 1'b1;
    tick(1);
    err = 1'b0;
    chk("t3b_err_seen", {31'd0, err_seen}, 32'd1);
    chk("t3b_state",    {30'd0, state},    32'd2);
    tick(2);
    rd(4'd0, "t3b_cycles", 16'h0001);
    chk("t3b_err_sticky", {31'd0, err_seen}, 32'd1);

    // Atomic 32-bit read while the counter rolls past a half-word boundary.
    do_clr();
    tick(1);
    en = 1'b0;
    force dut.g_ctr[0].u_ctr.cnt_q = 32'h0001_FFFF;
    tick(1);
    release dut.g_ctr[0].u_ctr.cnt_q;
    en = 1'b1;
    rd_en = 1'b1; rd_sel = 4'd0;
    tick(1);
    chk("t5_lo", {16'd0, rd_data}, 32'h0000_FFFF);
    rd_sel = 4'd1;
    tick(1);
    rd_en = 1'b0;
    en = 1'b0;
    chk("t5_hi_hold", {16'd0, rd_data}, 32'h0000_0001);
    rd(4'd0, "t5_live_lo", 16'h0001);
    rd(4'd1, "t5_live_hi", 16'h0002);

    // Saturation of counter 4 with sticky overflow.
    force dut.g_ctr[4].u_ctr.cnt_q = 32'hFFFF_FFFE;
    tick(1);
    release dut.g_ctr[4].u_ctr.cnt_q;
    en = 1'b1; dcache_req = 1'b1;
    tick(1);
    chk("t4_ovf_not_yet", {24'd0, ovf}, 32'h0000_0000);
    tick(2);
    en = 1'b0; dcache_req = 1'b0;
    chk("t4_ovf", {24'd0, ovf}, 32'h0000_0010);
    rd(4'd8, "t4_dc_lo", 16'hFFFF);
    rd(4'd9, "t4_dc_hi", 16'hFFFF);
    tick(2);
    chk("t4_ovf_sticky", {24'd0, ovf}, 32'h0000_0010);

    // Asynchronous reset in the middle of a read stream.
    en = 1'b1; rd_en = 1'b1; rd_sel = 4'd8;
    tick(1);
    chk("t6_pre_valid", {31'd0, rd_valid}, 32'd1);
    chk("t6_pre_data",  {16'd0, rd_data},  32'h0000_FFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("t6_rd_data",  {16'd0, rd_data},  32'd0);
    chk("t6_ovf",      {24'd0, ovf},      32'd0);
    chk("t6_state",    {30'd0, state},    32'd0);
    chk("t6_halted",   {31'd0, halted},   32'd0);
    chk("t6_err_seen", {31'd0, err_seen}, 32'd0);
    @(negedge clk);
    chk("t6_valid_held_low", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    tick(1);
    rd(4'd8, "t6_dc_lo", 16'h0000);
    rd(4'd9, "t6_dc_hi", 16'h0000);
    chk("t6_state_idle", {30'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
